// File: rtl/tx_packet_framer.sv
// Transmit packet framer: payload FIFO plus a preamble/SFD/length/payload
// serializer emitting MSB-first dibits under a valid/ready handshake.
module tx_packet_framer #(
   parameter int          DEPTH     = 64,
   parameter int          PRE_BYTES = 4,
   parameter logic [7:0]  SFD       = 8'hA7,
   localparam int         AW        = $clog2(DEPTH),
   localparam int         CW        = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          len_wr_en,
   input  logic [7:0]    len_data,
   input  logic          tx_en,
   output logic [1:0]    sym_out,
   output logic          sym_valid,
   input  logic          sym_ready,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] fifo_count,
   output logic          fifo_full,
   output logic          fifo_empty,
   output logic          overflow,
   output logic          start_err,
   output logic          aborted
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_SOF,
      S_LEN,
      S_PAY
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    shift_q, shift_d;
   logic [1:0]    dib_q, dib_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    cur_len_q, cur_len_d;
   logic          tx_en_q;
   logic          done_q, done_d;
   logic          ovf_q, ovf_d;
   logic          serr_q, serr_d;
   logic          abt_q, abt_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    mem_q [DEPTH];

   logic          full, rise, fall, len_ok;
   logic          push, pop, flush;
   logic [7:0]    head;

   assign full   = (count_q == CW'(DEPTH));
   assign rise   = tx_en & ~tx_en_q;
   assign fall   = ~tx_en & tx_en_q;
   assign len_ok = (len_q != 8'd0) && (32'(count_q) >= 32'(len_q));
   assign head   = mem_q[rptr_q];

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      dib_d     = dib_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      cur_len_d = cur_len_q;
      done_d    = 1'b0;
      ovf_d     = ovf_q;
      serr_d    = serr_q;
      abt_d     = abt_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      count_d   = count_q;
      pop       = 1'b0;
      flush     = 1'b0;

      if (len_wr_en) len_d = len_data;

      if (state_q == S_IDLE) begin
         if (rise) begin
            if (len_ok) begin
               state_d   = S_PRE;
               shift_d   = 8'h55;
               dib_d     = 2'd0;
               cnt_d     = 8'd0;
               cur_len_d = len_q;
               ovf_d     = 1'b0;
               serr_d    = 1'b0;
               abt_d     = 1'b0;
            end else begin
               serr_d = 1'b1;
            end
         end
      end else if (fall) begin
         state_d = S_IDLE;
         flush   = 1'b1;
         abt_d   = 1'b1;
      end else if (sym_ready) begin
         if (dib_q != 2'd3) begin
            shift_d = {shift_q[5:0], 2'b00};
            dib_d   = dib_q + 2'd1;
         end else begin
            // next byte loads on the same edge as the last dibit transfer
            dib_d = 2'd0;
            cnt_d = cnt_q + 8'd1;
            unique case (state_q)
               S_PRE: begin
                  if (cnt_q == 8'(PRE_BYTES - 1)) begin
                     state_d = S_SOF;
                     shift_d = SFD;
                     cnt_d   = 8'd0;
                  end else begin
                     shift_d = 8'h55;
                  end
               end
               S_SOF: begin
                  state_d = S_LEN;
                  shift_d = cur_len_q;
               end
               S_LEN: begin
                  state_d = S_PAY;
                  shift_d = head;
                  pop     = 1'b1;
                  cnt_d   = 8'd0;
               end
               S_PAY: begin
                  if (cnt_q == cur_len_q - 8'd1) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     shift_d = head;
                     pop     = 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end

      push = wr_en & ~full & ~flush;
      if (wr_en && full) ovf_d = 1'b1;

      if (flush) begin
         rptr_d  = wptr_q;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + AW'(1);
         if (pop)  rptr_d = rptr_q + AW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         dib_q     <= '0;
         cnt_q     <= '0;
         len_q     <= '0;
         cur_len_q <= '0;
         tx_en_q   <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         serr_q    <= 1'b0;
         abt_q     <= 1'b0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         dib_q     <= dib_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         cur_len_q <= cur_len_d;
         tx_en_q   <= tx_en;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
         serr_q    <= serr_d;
         abt_q     <= abt_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
      end
   end

   // storage needs no reset; occupancy is tracked by the pointers
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= wr_data;
   end

   assign busy       = (state_q != S_IDLE);
   assign sym_valid  = busy;
   assign sym_out    = busy ? shift_q[7:6] : 2'b00;
   assign done       = done_q;
   assign fifo_count = count_q;
   assign fifo_full  = full;
   assign fifo_empty = (count_q == '0);
   assign overflow   = ovf_q;
   assign start_err  = serr_q;
   assign aborted    = abt_q;

endmodule

// File: tb/tb_tx_packet_framer.sv
// Scoreboard bench for tx_packet_framer: expected dibits are queued at
// stimulus time and popped by a monitor on every accepted symbol.
module tb_tx_packet_framer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic       len_wr_en = 1'b0;
   logic [7:0] len_data = '0;
   logic       tx_en = 1'b0;
   logic [1:0] sym_out;
   logic       sym_valid;
   logic       sym_ready = 1'b1;
   logic       busy, done;
   logic [6:0] fifo_count;
   logic       fifo_full, fifo_empty;
   logic       overflow, start_err, aborted;

   tx_packet_framer dut (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_data(wr_data),
      .len_wr_en(len_wr_en), .len_data(len_data),
      .tx_en(tx_en),
      .sym_out(sym_out), .sym_valid(sym_valid), .sym_ready(sym_ready),
      .busy(busy), .done(done),
      .fifo_count(fifo_count),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .overflow(overflow), .start_err(start_err), .aborted(aborted)
   );

   always #5 clk = ~clk;

   int         total = 0;
   int         bad = 0;
   logic [1:0] exp_q[$];
   logic [7:0] pay_q[$];
   int         sent = 0;
   int         done_cnt = 0;
   bit         rnd_rdy = 1'b0;
   bit         hold_rdy = 1'b0;
   bit         stall = 1'b0;
   logic [1:0] hold_sym = '0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic exp_byte(input logic [7:0] b);
      for (int i = 3; i >= 0; i--) exp_q.push_back(b[2*i +: 2]);
   endtask

   task automatic exp_frame(input logic [7:0] len);
      for (int i = 0; i < 4; i++) exp_byte(8'h55);
      exp_byte(8'hA7);
      exp_byte(len);
      foreach (pay_q[i]) exp_byte(pay_q[i]);
   endtask

   task automatic wr(input logic [7:0] b);
      wr_en = 1'b1;
      wr_data = b;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic setlen(input logic [7:0] l);
      len_wr_en = 1'b1;
      len_data = l;
      @(posedge clk); #1;
      len_wr_en = 1'b0;
   endtask

   task automatic run_frame(input int budget, output int cyc);
      tx_en = 1'b1;
      cyc = 0;
      while (cyc < budget) begin
         @(posedge clk); #1;
         cyc++;
         if (done) break;
      end
      if (!done) chk("frame_timeout", int'(done), 1);
      tx_en = 1'b0;
   endtask

   always @(posedge clk) begin
      #2;
      if (hold_rdy) sym_ready = 1'b0;
      else if (rnd_rdy) sym_ready = 1'($urandom_range(0, 1));
      else sym_ready = 1'b1;
   end

   always @(negedge clk) begin
      if (reset) begin
         stall = 1'b0;
      end else begin
         if (stall && sym_valid) chk("stall_hold", sym_out, hold_sym);
         if (done) done_cnt++;
         if (sym_valid && sym_ready) begin
            sent++;
            if (exp_q.size() == 0) chk("sym_unexpected", int'(sym_valid), 0);
            else chk("sym", sym_out, exp_q.pop_front());
         end
         stall = sym_valid & ~sym_ready;
         hold_sym = sym_out;
      end
   end

   initial begin
      int cyc;
      int d0;

      #1;
      chk("rst_valid", sym_valid, 0);
      chk("rst_sym", sym_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_empty", fifo_empty, 1);
      chk("rst_full", fifo_full, 0);
      chk("rst_flags", {overflow, start_err, aborted}, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // nominal frame
      pay_q = '{8'hA5, 8'h3C, 8'hFF};
      foreach (pay_q[i]) wr(pay_q[i]);
      setlen(8'd3);
      chk("nom_count_pre", fifo_count, 3);
      exp_frame(8'd3);
      d0 = done_cnt;
      sent = 0;
      run_frame(100, cyc);
      chk("nom_latency", cyc, 37);
      chk("nom_busy_end", busy, 0);
      chk("nom_count", fifo_count, 0);
      chk("nom_empty", fifo_empty, 1);
      @(posedge clk); #1;
      chk("nom_syms", sent, 36);
      chk("nom_done_once", done_cnt - d0, 1);
      chk("nom_valid_end", sym_valid, 0);
      chk("nom_q_left", exp_q.size(), 0);

      // backpressure
      foreach (pay_q[i]) wr(pay_q[i]);
      exp_frame(8'd3);
      d0 = done_cnt;
      sent = 0;
      rnd_rdy = 1'b1;
      run_frame(1000, cyc);
      @(posedge clk); #1;
      rnd_rdy = 1'b0;
      chk("bp_syms", sent, 36);
      chk("bp_done_once", done_cnt - d0, 1);
      chk("bp_q_left", exp_q.size(), 0);
      chk("bp_count", fifo_count, 0);

      // refused starts
      wr(8'h11);
      wr(8'h22);
      setlen(8'd5);
      tx_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("ref_err", start_err, 1);
      chk("ref_valid", sym_valid, 0);
      chk("ref_busy", busy, 0);
      chk("ref_count", fifo_count, 2);
      tx_en = 1'b0;
      setlen(8'd0);
      tx_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("ref0_valid", sym_valid, 0);
      chk("ref0_count", fifo_count, 2);
      chk("ref0_err", start_err, 1);
      tx_en = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("ref_rst_empty", fifo_empty, 1);

      // overflow, then drain the full FIFO as a 64-byte frame
      pay_q.delete();
      for (int i = 0; i < 65; i++) begin
         if (i < 64) pay_q.push_back(8'(i * 3 + 1));
         wr(8'(i * 3 + 1));
      end
      chk("ovf_full", fifo_full, 1);
      chk("ovf_count", fifo_count, 64);
      chk("ovf_flag", overflow, 1);
      setlen(8'd64);
      exp_frame(8'd64);
      d0 = done_cnt;
      run_frame(400, cyc);
      chk("ovf_frame_lat", cyc, 281);
      chk("ovf_frame_count", fifo_count, 0);
      chk("ovf_cleared", overflow, 0);
      @(posedge clk); #1;
      chk("ovf_q_left", exp_q.size(), 0);
      chk("ovf_done_once", done_cnt - d0, 1);

      // abort after 30 symbols
      for (int i = 0; i < 64; i++) wr(8'(i * 3 + 1));
      exp_frame(8'd64);
      d0 = done_cnt;
      sent = 0;
      tx_en = 1'b1;
      cyc = 0;
      while (sent < 30 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("abt_reach30", sent, 30);
      hold_rdy = 1'b1;
      tx_en = 1'b0;
      @(posedge clk); #1;
      chk("abt_valid", sym_valid, 0);
      chk("abt_flag", aborted, 1);
      chk("abt_count", fifo_count, 0);
      chk("abt_busy", busy, 0);
      @(posedge clk); #1;
      chk("abt_no_done", done_cnt - d0, 0);
      chk("abt_syms", sent, 30);
      exp_q.delete();
      hold_rdy = 1'b0;

      // clean 1-byte restart
      pay_q = '{8'h5A};
      wr(8'h5A);
      setlen(8'd1);
      exp_frame(8'd1);
      d0 = done_cnt;
      run_frame(100, cyc);
      chk("rs_latency", cyc, 29);
      chk("rs_abt_clr", aborted, 0);
      @(posedge clk); #1;
      chk("rs_done_once", done_cnt - d0, 1);
      chk("rs_q_left", exp_q.size(), 0);

      // reset mid-payload
      pay_q = '{8'h81, 8'h42, 8'h24};
      foreach (pay_q[i]) wr(pay_q[i]);
      setlen(8'd3);
      exp_frame(8'd3);
      d0 = done_cnt;
      sent = 0;
      tx_en = 1'b1;
      cyc = 0;
      while (sent < 28 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("mr_reach28", sent, 28);
      #2 reset = 1'b1;
      #1;
      chk("mr_valid", sym_valid, 0);
      chk("mr_sym", sym_out, 0);
      chk("mr_busy", busy, 0);
      chk("mr_done", done, 0);
      chk("mr_count", fifo_count, 0);
      chk("mr_empty", fifo_empty, 1);
      chk("mr_full", fifo_full, 0);
      chk("mr_flags", {overflow, start_err, aborted}, 0);
      tx_en = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      chk("mr_idle", busy, 0);
      chk("mr_no_done", done_cnt - d0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
